// File: rtl/pipe_skid_stage.sv
// Elastic valid/ready pipeline stage with a main + skid buffer pair.
// Sustains one payload per cycle under backpressure, and in_ready is driven straight from a flop.
module pipe_skid_stage #(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RST_DATA = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StBusy  = 2'd1,
    StFull  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             out_valid_q, in_ready_q;
  logic [WIDTH-1:0] main_q, skid_q;
  logic             load_main_in, load_main_skid, load_skid;

  // The handshake outputs come from state_d and are registered, so nothing downstream sees a
  // combinational path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StEmpty;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      out_valid_q <= (state_d != StEmpty);
      in_ready_q  <= (state_d != StFull);
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = StEmpty;
    end else begin
      case (state_q)
        StEmpty: if (in_valid) state_d = StBusy;
        StBusy: begin
          if (in_valid && !out_ready)      state_d = StFull;
          else if (!in_valid && out_ready) state_d = StEmpty;
        end
        StFull:  if (out_ready) state_d = StBusy;
        default: state_d = StEmpty;
      endcase
    end
  end

  // Data-register enables. A flush suppresses every load, so the payload arriving in that
  // cycle is dropped.
  always_comb begin
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (!flush) begin
      case (state_q)
        StEmpty: load_main_in = in_valid;
        StBusy: begin
          load_main_in = in_valid && out_ready;
          load_skid    = in_valid && !out_ready;
        end
        StFull:  load_main_skid = out_ready;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q <= RST_DATA;
      skid_q <= RST_DATA;
    end else begin
      if (load_main_in) begin
        main_q <= in_data;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_data;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign in_ready  = in_ready_q;
  assign out_data  = main_q;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Scoreboard bench for pipe_skid_stage: the driver keeps an occupancy model and queues accepted
// payloads, and a negedge monitor compares the handshakes and out_data against that model.
module tb_pipe_skid_stage;

  localparam int unsigned      W        = 32;
  localparam logic [W-1:0]     RST_VAL  = 32'h5A5A_0000;

  logic         clk;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;

  int           n_cmp;
  int           n_err;
  int           m_cnt;
  logic [W-1:0] exp_q[$];

  pipe_skid_stage #(
    .WIDTH   (W),
    .RST_DATA(RST_VAL)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the model is updated at the edge using the same inputs as the DUT.
  task automatic cyc(input logic iv, input logic [W-1:0] d, input logic ordy, input logic fl);
    logic in_x, out_x;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    in_x  = iv && (m_cnt != 2);
    out_x = ordy && (m_cnt != 0);
    if (fl) begin
      m_cnt = 0;
      exp_q.delete();
    end else begin
      m_cnt = m_cnt + (in_x ? 1 : 0) - (out_x ? 1 : 0);
      if (in_x) exp_q.push_back(d);
    end
    #1;
  endtask

  // Monitor: the inputs for the next edge are already settled at the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      check("in_ready", 32'(in_ready), 32'(m_cnt != 2));
      check("out_valid", 32'(out_valid), 32'(m_cnt != 0));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL out_data: got %h expected no payload at %0t", out_data, $time);
        end else begin
          check("out_data", out_data, exp_q[0]);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    m_cnt     = 0;
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_data", out_data, RST_VAL);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Stream at full rate.
    cyc(1'b1, 32'h100, 1'b1, 1'b0);
    cyc(1'b1, 32'h104, 1'b1, 1'b0);
    cyc(1'b1, 32'h108, 1'b1, 1'b0);
    repeat (2) cyc(1'b0, '0, 1'b1, 1'b0);

    // Backpressure: fill both entries, and the held 0xC must wait for space.
    cyc(1'b1, 32'hA, 1'b0, 1'b0);
    cyc(1'b1, 32'hB, 1'b0, 1'b0);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_out_data", out_data, 32'hA);
    repeat (2) cyc(1'b1, 32'hC, 1'b0, 1'b0);
    check("bp_hold_data", out_data, 32'hA);
    cyc(1'b1, 32'hC, 1'b1, 1'b0);
    check("bp_skid_to_main", out_data, 32'hB);
    cyc(1'b1, 32'hC, 1'b1, 1'b0);
    check("bp_third", out_data, 32'hC);
    repeat (2) cyc(1'b0, '0, 1'b1, 1'b0);

    // Flush while full, with a competing input that must be dropped.
    cyc(1'b1, 32'hA, 1'b0, 1'b0);
    cyc(1'b1, 32'hB, 1'b0, 1'b0);
    cyc(1'b1, 32'hD, 1'b0, 1'b1);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_in_ready", 32'(in_ready), 32'd1);
    repeat (2) cyc(1'b0, '0, 1'b1, 1'b0);

    // Bubble between two payloads.
    cyc(1'b1, 32'h1, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    cyc(1'b1, 32'h2, 1'b1, 1'b0);
    repeat (2) cyc(1'b0, '0, 1'b1, 1'b0);

    // Asynchronous reset asserted mid-cycle while the stage is full.
    cyc(1'b1, 32'h77, 1'b0, 1'b0);
    cyc(1'b1, 32'h78, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2;
    rst   = 1'b1;
    m_cnt = 0;
    exp_q.delete();
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    check("arst_out_data", out_data, RST_VAL);
    @(posedge clk);
    #1 rst = 1'b0;

    // Random traffic against the scoreboard.
    for (int i = 0; i < 10000; i++) begin
      cyc(($urandom_range(0, 1) == 1), $urandom, ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 31) == 0));
    end
    repeat (3) cyc(1'b0, '0, 1'b1, 1'b0);
    check("drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
